// File: rtl/ysyx_23060240_axil_sram_if.sv
// AXI4-Lite bus bundle between the IFU/LSU arbiter (master) and the SRAM responder (slave).
interface ysyx_23060240_axil_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060240_axil_sram.sv
// AXI4-Lite SRAM responder with programmable response latency and OKAY/DECERR decode.
// Optional random extra latency: define YSYX_23060240_AXIL_SRAM_LFSR_DELAY_EN.
module ysyx_23060240_axil_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_23060240_axil_sram_if.slave saxi
);
  localparam int unsigned AW = $clog2(DEPTH);
`ifdef YSYX_23060240_AXIL_SRAM_LFSR_DELAY_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 4;
`endif

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] w_lat;

`ifdef YSYX_23060240_AXIL_SRAM_LFSR_DELAY_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 8'hA5;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_lat = CW'(LATENCY) + CW'(r_lfsr[2:0]);
`else
  assign w_lat = CW'(LATENCY);
`endif

  rstate_t       r_rstate;
  logic          r_arready, r_rvalid;
  logic [31:0]   r_rdata, r_raddr;
  logic [1:0]    r_rresp;
  logic [CW-1:0] r_rcnt;

  wstate_t       r_wstate;
  logic          r_awready, r_wready, r_bvalid, r_aw_got, r_w_got;
  logic [31:0]   r_waddr, r_wdata;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_bresp;
  logic [CW-1:0] r_wcnt;

  // Read port address: live bus address while idle, captured address afterwards.
  logic [31:0]   w_rd_addr, w_rd_off;
  logic          w_rd_ok;
  logic [AW-1:0] w_rd_idx;
  assign w_rd_addr = (r_rstate == R_IDLE) ? saxi.araddr : r_raddr;
  assign w_rd_off  = w_rd_addr - BASE_ADDR;
  assign w_rd_ok   = (w_rd_off[31:AW+2] == '0);
  assign w_rd_idx  = w_rd_off[AW+1:2];

  logic          w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit, w_wr_ok;
  logic [31:0]   w_wr_addr, w_wr_off, w_wr_data;
  logic [3:0]    w_wr_strb;
  logic [AW-1:0] w_wr_idx;
  assign w_aw_hs   = saxi.awvalid & r_awready;
  assign w_w_hs    = saxi.wvalid & r_wready;
  assign w_aw_have = r_aw_got | w_aw_hs;
  assign w_w_have  = r_w_got | w_w_hs;
  assign w_wr_addr = r_aw_got ? r_waddr : saxi.awaddr;
  assign w_wr_data = r_w_got ? r_wdata : saxi.wdata;
  assign w_wr_strb = r_w_got ? r_wstrb : saxi.wstrb;
  assign w_wr_off  = w_wr_addr - BASE_ADDR;
  assign w_wr_ok   = (w_wr_off[31:AW+2] == '0);
  assign w_wr_idx  = w_wr_off[AW+1:2];
  assign w_commit  = w_wr_ok &
                     (((r_wstate == W_IDLE) & w_aw_have & w_w_have & (w_lat == '0)) |
                      ((r_wstate == W_WAIT) & (r_wcnt == CW'(1))));

  logic [3:0] w_unused_off_bits;
  assign w_unused_off_bits = {w_rd_off[1:0], w_wr_off[1:0]};

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_raddr   <= '0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (saxi.arvalid && r_arready) begin
            r_raddr   <= saxi.araddr;
            r_arready <= 1'b0;
            r_rcnt    <= w_lat;
            if (w_lat == '0) begin
              r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
              r_rresp  <= w_rd_ok ? 2'b00 : 2'b11;
              r_rvalid <= 1'b1;
              r_rstate <= R_RESP;
            end else begin
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          r_rcnt <= r_rcnt - 1'b1;
          if (r_rcnt == CW'(1)) begin
            r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
            r_rresp  <= w_rd_ok ? 2'b00 : 2'b11;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (saxi.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // AW and W are latched independently; the transaction starts once both flags are (or become) set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_waddr   <= saxi.awaddr;
            r_aw_got  <= 1'b1;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= saxi.wdata;
            r_wstrb  <= saxi.wstrb;
            r_w_got  <= 1'b1;
            r_wready <= 1'b0;
          end
          if (w_aw_have && w_w_have) begin
            r_wcnt <= w_lat;
            if (w_lat == '0) begin
              r_bresp  <= w_wr_ok ? 2'b00 : 2'b11;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end else begin
              r_wstate <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          r_wcnt <= r_wcnt - 1'b1;
          if (r_wcnt == CW'(1)) begin
            r_bresp  <= w_wr_ok ? 2'b00 : 2'b11;
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (saxi.bready) begin
            r_bvalid  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign saxi.arready = r_arready;
  assign saxi.rvalid  = r_rvalid;
  assign saxi.rdata   = r_rdata;
  assign saxi.rresp   = r_rresp;
  assign saxi.awready = r_awready;
  assign saxi.wready  = r_wready;
  assign saxi.bvalid  = r_bvalid;
  assign saxi.bresp   = r_bresp;
endmodule

// File: tb/tb_ysyx_23060240_axil_sram.sv
// Scoreboard bench for the AXI4-Lite SRAM: drivers push expected responses, monitors pop and compare.
module tb_ysyx_23060240_axil_sram;
  localparam logic [31:0] TB_BASE  = 32'h8000_0000;
  localparam int unsigned TB_DEPTH = 1024;
  localparam int unsigned TB_LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060240_axil_sram_if bus ();

  ysyx_23060240_axil_sram #(
    .BASE_ADDR(TB_BASE),
    .DEPTH    (TB_DEPTH),
    .LATENCY  (TB_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .saxi(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit [31:0]   model [int];
  logic [33:0] rexp_q[$];
  logic [1:0]  bexp_q[$];
  int          rhs_q[$];
  int          bhs_q[$];
  bit          r_active = 0, b_active = 0;
  bit          aw_f = 0, w_f = 0;
  int          aw_c = 0, w_c = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_lat(input string nm, input int lat);
    int lo, hi;
    lo = TB_LAT;
`ifdef YSYX_23060240_AXIL_SRAM_LFSR_DELAY_EN
    hi = TB_LAT + 7;
`else
    hi = TB_LAT;
`endif
    checks++;
    if (lat < lo || lat > hi) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=[%0d,%0d] (cycle %0d)", nm, lat, lo, hi, cyc);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = a;
    lo = TB_BASE;
    hi = lo + 4 * longint'(TB_DEPTH);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - TB_BASE) >> 2);
  endfunction

  task automatic expect_read(input logic [31:0] a);
    if (in_rng(a)) rexp_q.push_back({2'b00, model[widx(a)]});
    else           rexp_q.push_back({2'b11, 32'h0});
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit [31:0] w;
    if (in_rng(a)) begin
      w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[widx(a)] = w;
      bexp_q.push_back(2'b00);
    end else begin
      bexp_q.push_back(2'b11);
    end
  endtask

  // Handshake bookkeeping on the active edge (outputs still hold pre-edge values here).
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      rhs_q.delete(); bhs_q.delete();
      aw_f = 0; w_f = 0; r_active = 0; b_active = 0;
    end else begin
      if (bus.arvalid && bus.arready) rhs_q.push_back(cyc);
      if (bus.awvalid && bus.awready) begin aw_f = 1; aw_c = cyc; end
      if (bus.wvalid && bus.wready) begin w_f = 1; w_c = cyc; end
      if (aw_f && w_f) begin
        bhs_q.push_back(aw_c > w_c ? aw_c : w_c);
        aw_f = 0; w_f = 0;
      end
      if (bus.rvalid && bus.rready) begin
        if (rexp_q.size() > 0) void'(rexp_q.pop_front());
        r_active = 0;
      end
      if (bus.bvalid && bus.bready) begin
        if (bexp_q.size() > 0) void'(bexp_q.pop_front());
        b_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid) begin
        if (!r_active) begin
          r_active = 1;
          if (rhs_q.size() == 0) chk("r_unexpected", 32'(bus.rvalid), 32'h0);
          else chk_lat("r_latency", cyc - rhs_q.pop_front());
        end
        if (rexp_q.size() == 0) chk("r_no_expect", 32'(bus.rvalid), 32'h0);
        else begin
          chk("rdata", bus.rdata, rexp_q[0][31:0]);
          chk("rresp", 32'(bus.rresp), 32'(rexp_q[0][33:32]));
        end
        chk("arready_busy", 32'(bus.arready), 32'h0);
      end
      if (bus.bvalid) begin
        if (!b_active) begin
          b_active = 1;
          if (bhs_q.size() == 0) chk("b_unexpected", 32'(bus.bvalid), 32'h0);
          else chk_lat("b_latency", cyc - bhs_q.pop_front());
        end
        if (bexp_q.size() == 0) chk("b_no_expect", 32'(bus.bvalid), 32'h0);
        else chk("bresp", 32'(bus.bresp), 32'(bexp_q[0]));
        chk("awwready_busy", 32'({bus.awready, bus.wready}), 32'h0);
      end
    end
  end

  task automatic bus_read(input logic [31:0] a, input int stall);
    int n;
    bus.rready  = (stall == 0);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("ar_timeout", 32'(n), 32'h0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("r_timeout", 32'(n), 32'h0);
    repeat (stall) @(negedge clk);
    bus.rready = 1'b1;
    @(negedge clk);
    chk("r_release", 32'({bus.arready, bus.rvalid}), 32'h2);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int stall);
    int t, n;
    bit aw_on, w_on, aw_done, w_done, aw_hs, w_hs;
    t = 0; aw_on = 0; w_on = 0; aw_done = 0; w_done = 0;
    bus.bready = (stall == 0);
    while (!(aw_done && w_done) && t < 80) begin
      if (!aw_done && !aw_on && t >= awd) begin bus.awaddr = a; bus.awvalid = 1'b1; aw_on = 1; end
      if (!w_done && !w_on && t >= wd) begin
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; w_on = 1;
      end
      aw_hs = aw_on && bus.awready;
      w_hs  = w_on && bus.wready;
      @(negedge clk);
      t++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_on = 0; aw_done = 1; end
      if (w_hs) begin bus.wvalid = 1'b0; w_on = 0; w_done = 1; end
    end
    if (t >= 80) chk("aw_w_timeout", 32'(t), 32'h0);
    n = 0;
    while (!bus.bvalid && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("b_timeout", 32'(n), 32'h0);
    repeat (stall) @(negedge clk);
    bus.bready = 1'b1;
    @(negedge clk);
    chk("b_release", 32'({bus.awready, bus.wready, bus.bvalid}), 32'h6);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall);
    expect_read(a);
    bus_read(a, stall);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int stall);
    model_write(a, d, s);
    bus_write(a, d, s, awd, wd, stall);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return TB_BASE - 32'(4 * $urandom_range(1, 16));
    if (k == 1) return TB_BASE + 32'(4 * TB_DEPTH) + 32'(4 * $urandom_range(0, 15));
    return TB_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] a, a2;
    int i2, j2;
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'h7);
    chk("rst_valids", 32'({bus.rvalid, bus.bvalid}), 32'h0);
    chk("rst_resps", 32'({bus.rresp, bus.bresp}), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    bus.rready = 1; bus.bready = 1;

    for (int i = 0; i < 16; i++) do_write(TB_BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h8000_0010, 0);
    chk("model_deadbeef", model[4], 32'hDEAD_BEEF);
    do_write(32'h8000_0010, 32'h0000_00AA, 4'b0001, 3, 0, 0);
    do_read(32'h8000_0010, 0);

    do_read(32'h7FFF_FFFC, 0);
    do_write(TB_BASE + 32'(4 * TB_DEPTH), 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(TB_BASE, 0);
    do_write(TB_BASE + 32'h14, 32'hFFFF_FFFF, 4'h0, 1, 0, 0);
    do_read(TB_BASE + 32'h14, 0);

    do_read(TB_BASE + 32'h8, 5);

    // Same-word collision: read sample and write commit share one edge.
    expect_read(TB_BASE + 32'h18);
    model_write(TB_BASE + 32'h18, 32'hC0FF_EE00, 4'hF);
    fork
      bus_read(TB_BASE + 32'h18, 0);
      bus_write(TB_BASE + 32'h18, 32'hC0FF_EE00, 4'hF, 0, 0, 0);
    join
    do_read(TB_BASE + 32'h18, 0);

    bus.awaddr = TB_BASE + 32'h1C; bus.wdata = ~model[7]; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_bvalid_after_rst", 32'(bus.bvalid), 32'h0);
    end
    do_read(TB_BASE + 32'h1C, 0);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 4))
        0, 1: do_read(rand_addr(), $urandom_range(0, 2));
        2, 3: do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2));
        default: begin
          i2 = $urandom_range(0, 15);
          j2 = (i2 + $urandom_range(1, 15)) % 16;
          a  = TB_BASE + 32'(4 * i2);
          a2 = TB_BASE + 32'(4 * j2);
          expect_read(a);
          model_write(a2, $urandom, 4'($urandom));
          fork
            bus_read(a, $urandom_range(0, 2));
            bus_write(a2, model[j2], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
          join
        end
      endcase
    end

    repeat (5) @(negedge clk);
    chk("rexp_drained", 32'(rexp_q.size()), 32'h0);
    chk("bexp_drained", 32'(bexp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_23060240_axil_sram.md
# ysyx_23060240_axil_sram

AXI4-Lite responder modelling the NPC's main memory, sitting on the slave side of the IFU/LSU arbiter's `saxi_*` bus. It serves single-beat 32-bit reads and writes over a word-addressed array with a programmable response latency. It drives OKAY or DECERR responses. It gives both fetch and load/store paths a realistic handshake target.

## Interface
Parameters:
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0
- `DEPTH`, 1024, array size in 32-bit words (power of two)
- `LATENCY`, 1, extra wait cycles between request capture and response (0..15)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `araddr` in 32: read address
- `arvalid` in 1 / `arready` out 1: read address handshake
- `rdata` out 32: read data
- `rresp` out 2: 2'b00 OKAY, 2'b11 DECERR
- `rvalid` out 1 / `rready` in 1: read data handshake
- `awaddr` in 32: write address
- `awvalid` in 1 / `awready` out 1: write address handshake
- `wdata` in 32 / `wstrb` in 4: write data and byte enables (bit i → byte i)
- `wvalid` in 1 / `wready` out 1: write data handshake
- `bresp` out 2: write response
- `bvalid` out 1 / `bready` in 1: write response handshake

## Operation
- Decode: word index = (addr − BASE_ADDR) >> 2; addr[1:0] ignored. The address is in range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH.
- Read FSM has three states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: `arready`=1. On arvalid&arready, capture the address and load the counter with the latency value. Go to R_RESP if the latency is 0, else go to R_WAIT.
  - R_WAIT: decrement the counter. On reaching 0, go to R_RESP.
  - Entering R_RESP: sample the array into `rdata` and set `rresp`. Out of range gives `rdata`=0 and DECERR.
  - R_RESP: `rvalid`=1. `rdata`/`rresp` are held stable until rvalid&rready, then return to R_IDLE.
- Write FSM has three states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AW and W are captured independently, in either order or in the same cycle. `awready`=1 until AW is captured; `wready`=1 until W is captured. Once both are held, load the counter and go to W_WAIT, or go straight to W_RESP if the latency is 0.
  - Entering W_RESP: commit the bytes whose `wstrb` bit is set. Out of range gives no commit and DECERR; otherwise OKAY.
  - W_RESP: `bvalid`=1 until bvalid&bready, then clear the captured flags and return to W_IDLE.
- Read and write FSMs run concurrently. The array has one write port and one read port.
- Same-word collision: if read sampling and write commit happen on the same edge, the read returns the pre-write data.
- wstrb=0: the write is accepted and gives OKAY with no array change.
- Array contents are not reset.

## Timing
- Reset values: `arready`=1, `awready`=1, `wready`=1, `rvalid`=0, `bvalid`=0, `rdata`=0, `rresp`=0, `bresp`=0. Both FSMs are in IDLE and the counters are 0.
- Read: if AR is sampled at edge N, `rvalid` is high after edge N+LATENCY. LATENCY=0 means `rvalid` is high in the cycle right after the handshake.
- Write: if the later of AW/W is sampled at edge N, `bvalid` is high after edge N+LATENCY.
- The minimum issue interval per channel is LATENCY+2 cycles. `arready` stays 0 from the AR handshake until the R handshake completes; the same applies to AW/W and B.
- Readies do not depend combinationally on valids. Valids never drop before their handshake.
- Reset mid-operation: any pending transaction is discarded. A write that has not yet entered W_RESP is never committed. No `rvalid`/`bvalid` appears after release.

## Configuration
- `YSYX_23060240_AXIL_SRAM_LFSR_DELAY_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances every cycle.
  - The latency loaded at each capture is LATENCY + lfsr[2:0] (0..7 extra cycles). The counter is 5 bits wide.
  - Read and write use the same LFSR value if they capture on the same edge.
- Undefined: no LFSR is present and the latency is always exactly LATENCY.

## Test plan
- Reset released with all inputs 0 → arready=awready=wready=1, rvalid=bvalid=0, rresp=bresp=0.
- Write 0x8000_0010 with wdata=0xDEADBEEF, wstrb=4'hF, LATENCY=1 → bvalid after edge N+1 with bresp=0. A later read of 0x8000_0010 gives rdata=0xDEADBEEF, rresp=0, rvalid after edge N+1.
- Write 0x8000_0010 with wdata=0x0000_00AA, wstrb=4'b0001, W sent 3 cycles before AW → B OKAY, and a readback gives 0xDEADBEAA.
- Read 0x7FFF_FFFC, then write 0x8000_0000+4·DEPTH → rresp=2'b11 with rdata=0, bresp=2'b11, and array unchanged.
- rready held low 5 cycles after rvalid → rvalid and rdata stable, and arready=0 throughout. Handshake completes and arready=1 the next cycle.
- rst asserted while in W_WAIT → bvalid never rises and the target word is unchanged. With the LFSR macro defined, 100 reads each have rvalid latency within [LATENCY, LATENCY+7].
